fregwb_arb: RTL



---
 rtl/fpu_wb_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/fregwb_arb.sv | 95 +++++++++
 3 files changed

// File: rtl/fpu_wb_pkg.sv
// Shared types for the FP register-file write-back arbiter.
// Source encoding, round-robin pointer and register-mask helper.
package fpu_wb_pkg;

  localparam int unsigned NUM_FREGS = 32;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_FMA,
    WB_DIV,
    WB_LD
  } wbsrc_t;

  typedef enum logic {
    FAV_REQ0,
    FAV_REQ1
  } rrptr_t;

  // One-hot register mask, or all-zero when the request is inactive.
  function automatic logic [NUM_FREGS-1:0] reg_mask(input logic [4:0] rd,
                                                     input logic       en);
    logic [NUM_FREGS-1:0] m;
    m = '0;
    if (en) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a one-bit pointer.
// Ready depends only on the other requester and the pointer, never on its own request.
module rr_arb2
  import fpu_wb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] ready,
  output logic [1:0] gnt
);

  rrptr_t ptr, ptr_nxt;

  always_ff @(posedge clk) begin
    if (reset) ptr <= FAV_REQ1;
    else       ptr <= ptr_nxt;
  end

  // The pointer only moves when both requesters contend and one is served.
  always_comb begin
    ptr_nxt = ptr;
    if (gnt[0] && req[1])      ptr_nxt = FAV_REQ1;
    else if (gnt[1] && req[0]) ptr_nxt = FAV_REQ0;
  end

  always_comb begin
    ready[0] = en & (~req[1] | (ptr == FAV_REQ0));
    ready[1] = en & (~req[0] | (ptr == FAV_REQ1));
    gnt      = ready & req;
  end

endmodule

// File: rtl/fregwb_arb.sv
// Write-back arbiter for the FP register file write port plus pending-write scoreboard.
// FMA has absolute priority; div/sqrt and load share the remainder round-robin.
module fregwb_arb
  import fpu_wb_pkg::*;
#(
  parameter int unsigned FLEN = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IssueValid,
  input  logic [4:0]           IssueRd,
  input  logic                 FmaValid,
  input  logic [4:0]           FmaRd,
  input  logic [FLEN-1:0]      FmaData,
  input  logic                 DivValid,
  input  logic [4:0]           DivRd,
  input  logic [FLEN-1:0]      DivData,
  output logic                 DivReady,
  input  logic                 LdValid,
  input  logic [4:0]           LdRd,
  input  logic [FLEN-1:0]      LdData,
  output logic                 LdReady,
  output logic                 WE4,
  output logic [4:0]           A4,
  output logic [FLEN-1:0]      WD4,
  output logic [NUM_FREGS-1:0] FRegBusy
);

  logic            arb_en;
  logic [1:0]      arb_req, arb_ready, arb_gnt;
  wbsrc_t          src;
  logic [4:0]      wr_rd;
  logic [FLEN-1:0] wr_data;
  logic [NUM_FREGS-1:0] busy_nxt;

  assign arb_en  = ~FmaValid;
  assign arb_req = {LdValid, DivValid};

  rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   (arb_req),
    .ready (arb_ready),
    .gnt   (arb_gnt)
  );

  assign DivReady = arb_ready[0];
  assign LdReady  = arb_ready[1];

  always_comb begin
    src = WB_NONE;
    if (FmaValid)        src = WB_FMA;
    else if (arb_gnt[0]) src = WB_DIV;
    else if (arb_gnt[1]) src = WB_LD;
  end

  always_comb begin
    wr_rd   = '0;
    wr_data = '0;
    case (src)
      WB_FMA:  begin wr_rd = FmaRd; wr_data = FmaData; end
      WB_DIV:  begin wr_rd = DivRd; wr_data = DivData; end
      WB_LD:   begin wr_rd = LdRd;  wr_data = LdData;  end
      default: begin wr_rd = '0;    wr_data = '0;      end
    endcase
  end

  // A4/WD4 hold their last value when idle; only WE4 drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      WE4 <= 1'b0;
      A4  <= '0;
      WD4 <= '0;
    end else if (src != WB_NONE) begin
      WE4 <= 1'b1;
      A4  <= wr_rd;
      WD4 <= wr_data;
    end else begin
      WE4 <= 1'b0;
    end
  end

  // Set is applied after clear so a same-cycle issue to the written register wins.
  always_comb begin
    busy_nxt = (FRegBusy & ~reg_mask(wr_rd, src != WB_NONE))
             | reg_mask(IssueRd, IssueValid);
  end

  always_ff @(posedge clk) begin
    if (reset) FRegBusy <= '0;
    else       FRegBusy <= busy_nxt;
  end

endmodule
